// File: rtl/iiitb_icg_pkg.sv
// Shared types and constants for the clock-gating demonstrator.
// No logic: reset value and default data type only.
package iiitb_icg_pkg;

  localparam int WIDTH_DEF = 1;

  typedef logic [WIDTH_DEF-1:0] data_t;

  localparam data_t RST_VAL = '0;

endpackage

// File: rtl/iiitb_icg_cell.sv
// Latch-based glitch-free clock gate, gclk = clk & en_l; optional ICG_TEST_EN adds test_en override.
// Zero latency: the enable is captured while clk is low; no backpressure.
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
`ifdef ICG_TEST_EN
  input  logic test_en,
`endif
  output logic gclk
);

  logic w_en_in;
  logic r_en_l;

`ifdef ICG_TEST_EN
  assign w_en_in = en | test_en;
`else
  assign w_en_in = en;
`endif

  // Transparent only while clk is low, so an enable change in the high phase cannot cut a pulse.
  always_latch begin
    if (!rst_n) begin
      r_en_l = 1'b0;
    end else if (!clk) begin
      r_en_l = w_en_in;
    end
  end

  assign gclk = clk & r_en_l;

endmodule

// File: rtl/iiitb_icg_core.sv
// Two register banks: q0 on the free-running clk, q1 on the gated clock (ICG_TEST_EN adds test_en).
// One-edge latency from d to q; q1 holds while the gate is closed; no backpressure.
module iiitb_icg_core
  import iiitb_icg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
`ifdef ICG_TEST_EN
  input  logic             test_en,
`endif
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1
);

  localparam logic [WIDTH-1:0] BANK_RST = WIDTH'(RST_VAL);

  logic             w_gclk;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;

  iiitb_icg_cell u_icg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in),
`ifdef ICG_TEST_EN
    .test_en (test_en),
`endif
    .gclk    (w_gclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= BANK_RST;
    end else begin
      r_q0 <= d0;
    end
  end

  always_ff @(posedge w_gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= BANK_RST;
    end else begin
      r_q1 <= d1;
    end
  end

  assign q0 = r_q0;
  assign q1 = r_q1;

endmodule

// File: tb/tb_iiitb_icg_core.sv
// Directed bench for iiitb_icg_core: reset, open/closed gate, glitch immunity, mid-high release.
module tb_iiitb_icg_core;

  logic clk;
  logic rst_n;
  logic in;
  logic [0:0] d0;
  logic [0:0] d1;
  logic [0:0] q0;
  logic [0:0] q1;
`ifdef ICG_TEST_EN
  logic test_en;
`endif

  int n_vec;
  int n_err;

  iiitb_icg_core #(.WIDTH(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
`ifdef ICG_TEST_EN
    .test_en (test_en),
`endif
    .d0      (d0),
    .d1      (d1),
    .q0      (q0),
    .q1      (q1)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:0] pat;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in    = 1'b1;
    d0    = 1'b1;
    d1    = 1'b1;
`ifdef ICG_TEST_EN
    test_en = 1'b0;
`endif

    // Reset held across several edges with everything asserted.
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      chk("rst_q0", 8'(q0), 8'h0);
      chk("rst_q1", 8'(q1), 8'h0);
      chk("rst_gclk", 8'(dut.w_gclk), 8'h0);
    end

    // Release while clk is high: latch still closed at this high phase.
    #4;
    rst_n = 1'b1;
    #5;
    chk("rel_q1_hold", 8'(q1), 8'h0);
    chk("rel_gclk", 8'(dut.w_gclk), 8'h0);
    @(negedge clk);
    d0 = 1'b0;
    d1 = 1'b1;
    edge_sample();
    chk("rel_q0", 8'(q0), 8'h0);
    chk("rel_q1_load", 8'(q1), 8'h1);

    // Gate open: q1 follows d1 every edge, identical to q0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in  = 1'b1;
      pat = (i % 2 == 0) ? 1'b0 : 1'b1;
      d0  = pat;
      d1  = pat;
      edge_sample();
      chk("open_q1", 8'(q1), 8'(pat));
      chk("open_q0", 8'(q0), 8'(pat));
    end

    // Gate closed: q1 stuck at 1 while d1 toggles; q0 keeps tracking.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in  = 1'b0;
      pat = (i % 2 == 0) ? 1'b1 : 1'b0;
      d0  = pat;
      d1  = ~pat;
      edge_sample();
      chk("closed_q1", 8'(q1), 8'h1);
      chk("closed_q0", 8'(q0), 8'(pat));
    end

    // Enable pulse entirely inside the high phase must not reach the gated clock.
    #9;
    in = 1'b1;
    #5;
    chk("glitch_gclk", 8'(dut.w_gclk), 8'h0);
    #5;
    in = 1'b0;
    @(negedge clk);
    d0 = 1'b1;
    d1 = 1'b0;
    edge_sample();
    chk("glitch_q1", 8'(q1), 8'h1);
    chk("glitch_q0", 8'(q0), 8'h1);

`ifdef ICG_TEST_EN
    @(negedge clk);
    test_en = 1'b1;
    d1 = 1'b0;
    edge_sample();
    chk("test_q1_lo", 8'(q1), 8'h0);
    @(negedge clk);
    d1 = 1'b1;
    edge_sample();
    chk("test_q1_hi", 8'(q1), 8'h1);
    @(negedge clk);
    test_en = 1'b0;
    d1 = 1'b0;
    edge_sample();
    chk("test_off_q1", 8'(q1), 8'h1);
`endif

    // Asynchronous reset in the low phase clears both banks immediately.
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_q0", 8'(q0), 8'h0);
    chk("arst_q1", 8'(q1), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
